// File: rtl/operand_entry_ctrl.sv
// Button-driven operand entry sequencer: debounces the "do operation" button and
// steps LOAD_A -> LOAD_B -> EXEC -> SHOW, holding A, B, the op code and valid flags.
module operand_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       clr,
    input  logic [7:0] data_in,
    input  logic [3:0] op_sel,
    output logic [7:0] a_reg,
    output logic [7:0] b_reg,
    output logic [3:0] op_reg,
    output logic       a_valid,
    output logic       b_valid,
    output logic       exec_pulse,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EXEC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_btn_db;
    logic             r_btn_db_d;
    logic [CNT_W-1:0] r_cnt;
    logic             w_btn_s;
    logic             w_press;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_cap_a;
    logic             w_cap_b;
    logic             w_cap_op;
    logic             w_wrap;

    logic [7:0]       r_a;
    logic [7:0]       r_b;
    logic [3:0]       r_op;
    logic             r_a_valid;
    logic             r_b_valid;
    logic             r_exec;

    assign w_btn_s = r_sync2;
    // Rising edge of the debounced level only; releases never count as a press.
    assign w_press = r_btn_db & ~r_btn_db_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= btn_raw;
            r_sync2    <= r_sync1;
            r_btn_db_d <= r_btn_db;
            if (w_btn_s == r_btn_db) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_MAX) begin
                r_btn_db <= w_btn_s;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + LP_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Clear wins over a simultaneous press, which is simply dropped.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = LOAD_A;
        end else if (w_press) begin
            case (r_state)
                LOAD_A:  w_state_nxt = LOAD_B;
                LOAD_B:  w_state_nxt = EXEC;
                EXEC:    w_state_nxt = SHOW;
                SHOW:    w_state_nxt = LOAD_A;
                default: w_state_nxt = LOAD_A;
            endcase
        end
    end

    always_comb begin
        w_cap_a  = 1'b0;
        w_cap_b  = 1'b0;
        w_cap_op = 1'b0;
        w_wrap   = 1'b0;
        if (!clr && w_press) begin
            case (r_state)
                LOAD_A:  w_cap_a  = 1'b1;
                LOAD_B:  w_cap_b  = 1'b1;
                EXEC:    w_cap_op = 1'b1;
                SHOW:    w_wrap   = 1'b1;
                default: w_wrap   = 1'b0;
            endcase
        end
    end

    // Operand registers survive the SHOW wrap so the display persists.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_exec    <= 1'b0;
        end else if (clr) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_exec    <= 1'b0;
        end else begin
            r_exec <= w_cap_op;
            if (w_cap_a) begin
                r_a       <= data_in;
                r_a_valid <= 1'b1;
                r_b_valid <= 1'b0;
            end
            if (w_cap_b) begin
                r_b       <= data_in;
                r_b_valid <= 1'b1;
            end
            if (w_cap_op) begin
                r_op <= op_sel;
            end
            if (w_wrap) begin
                r_a_valid <= 1'b0;
                r_b_valid <= 1'b0;
            end
        end
    end

    assign a_reg      = r_a;
    assign b_reg      = r_b;
    assign op_reg     = r_op;
    assign a_valid    = r_a_valid;
    assign b_valid    = r_b_valid;
    assign exec_pulse = r_exec;
    assign state      = r_state;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Bench for operand_entry_ctrl with a short debounce window: table of press
// vectors with expected register state, plus bounce, hold, clear and reset sequences.
module tb_operand_entry_ctrl;

    typedef struct {
        logic [7:0] din;
        logic [3:0] op;
        logic [1:0] st;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] o;
        logic       av;
        logic       bv;
        logic       ex;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       clr;
    logic [7:0] data_in;
    logic [3:0] op_sel;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [3:0] op_reg;
    logic       a_valid;
    logic       b_valid;
    logic       exec_pulse;
    logic [1:0] state;

    int   n_chk = 0;
    int   n_err = 0;
    vec_t exp_q[$];
    vec_t tbl[5];

    operand_entry_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .clr       (clr),
        .data_in   (data_in),
        .op_sel    (op_sel),
        .a_reg     (a_reg),
        .b_reg     (b_reg),
        .op_reg    (op_reg),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .exec_pulse(exec_pulse),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] din, input logic [3:0] op,
                                input logic [1:0] st, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] o,
                                input logic av, input logic bv, input logic ex);
        vec_t v;
        v.din = din; v.op = op; v.st = st; v.a = a; v.b = b; v.o = o;
        v.av = av; v.bv = bv; v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, ".state"}, state, e.st);
        chk({tag, ".a_reg"}, a_reg, e.a);
        chk({tag, ".b_reg"}, b_reg, e.b);
        chk({tag, ".op_reg"}, op_reg, e.o);
        chk({tag, ".a_valid"}, a_valid, e.av);
        chk({tag, ".b_valid"}, b_valid, e.bv);
        chk({tag, ".exec_pulse"}, exec_pulse, e.ex);
    endtask

    task automatic release_btn();
        logic [1:0] st0;
        st0 = state;
        btn_raw = 1'b0;
        repeat (10) @(negedge clk);
        chk("release_no_press", state, st0);
    endtask

    // Clean press; expectation queued at drive time, checked when the state moves.
    task automatic do_press(input string tag, input vec_t v, input bit rel);
        logic [1:0] prev;
        int         cyc;
        vec_t       e;
        data_in = v.din;
        op_sel  = v.op;
        exp_q.push_back(v);
        prev    = state;
        btn_raw = 1'b1;
        cyc     = 0;
        while (cyc < 20 && state == prev) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".latency"}, cyc, 7);
        e = exp_q.pop_front();
        check_all(tag, e);
        data_in = ~v.din;
        op_sel  = ~v.op;
        @(negedge clk);
        chk({tag, ".exec_after"}, exec_pulse, 1'b0);
        chk({tag, ".state_after"}, state, e.st);
        if (rel) release_btn();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t z;
        tbl[0] = mk(8'h12, 4'hF, 2'd1, 8'h12, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0);
        tbl[1] = mk(8'h34, 4'hE, 2'd2, 8'h12, 8'h34, 4'h0, 1'b1, 1'b1, 1'b0);
        tbl[2] = mk(8'hAA, 4'h5, 2'd3, 8'h12, 8'h34, 4'h5, 1'b1, 1'b1, 1'b1);
        tbl[3] = mk(8'h55, 4'h3, 2'd0, 8'h12, 8'h34, 4'h5, 1'b0, 1'b0, 1'b0);
        tbl[4] = mk(8'h9C, 4'h1, 2'd1, 8'h9C, 8'h34, 4'h5, 1'b1, 1'b0, 1'b0);
        z      = mk(8'h00, 4'h0, 2'd0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);

        reset = 1'b0; btn_raw = 1'b0; clr = 1'b0; data_in = 8'h00; op_sel = 4'h0;
        repeat (2) @(negedge clk);
        check_all("reset_held", z);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all("reset_released", z);

        do_press("first_press", mk(8'h3C, 4'h0, 2'd1, 8'h3C, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0), 1'b1);

        // Bouncing input: four short levels, none long enough to be accepted.
        data_in = 8'h77;
        for (int k = 0; k < 4; k++) begin
            btn_raw = (k % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                chk("bounce_state", state, 2'd1);
                chk("bounce_b_valid", b_valid, 1'b0);
            end
        end
        do_press("bounce_settle", mk(8'h77, 4'h0, 2'd2, 8'h3C, 8'h77, 4'h0, 1'b1, 1'b1, 1'b0), 1'b1);

        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_all("clear_idle", z);

        for (int i = 0; i < 5; i++) begin
            do_press($sformatf("tbl%0d", i), tbl[i], 1'b1);
        end

        // Held button: one capture of B, then nothing until release and re-press.
        do_press("hold_cap", mk(8'h61, 4'h0, 2'd2, 8'h9C, 8'h61, 4'h5, 1'b1, 1'b1, 1'b0), 1'b0);
        for (int k = 0; k < 5; k++) begin
            repeat (10) @(negedge clk);
            data_in = 8'($urandom);
            chk("hold_state", state, 2'd2);
            chk("hold_b_reg", b_reg, 8'h61);
        end
        release_btn();
        do_press("hold_exec", mk(8'hF0, 4'h7, 2'd3, 8'h9C, 8'h61, 4'h7, 1'b1, 1'b1, 1'b1), 1'b1);
        do_press("wrap", mk(8'h0F, 4'h2, 2'd0, 8'h9C, 8'h61, 4'h7, 1'b0, 1'b0, 1'b0), 1'b1);
        do_press("reload_a", mk(8'h2D, 4'h2, 2'd1, 8'h2D, 8'h61, 4'h7, 1'b1, 1'b0, 1'b0), 1'b1);

        // Clear lands on the same edge as the press in LOAD_B.
        data_in = 8'hEE;
        btn_raw = 1'b1;
        repeat (6) @(negedge clk);
        chk("clrpress_pre_state", state, 2'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_all("clrpress", z);
        repeat (20) @(negedge clk);
        check_all("clrpress_held", z);
        release_btn();

        do_press("rst_a", mk(8'h11, 4'h0, 2'd1, 8'h11, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0), 1'b1);
        do_press("rst_b", mk(8'h22, 4'h0, 2'd2, 8'h11, 8'h22, 4'h0, 1'b1, 1'b1, 1'b0), 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", z);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_press("post_reset", mk(8'h42, 4'h9, 2'd1, 8'h42, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
